// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_DEFAULT     = 4;
   localparam int CNT_W_DEFAULT = $clog2(2 * N_DEFAULT + 1);

   // Counter must hold the value 2N, hence 2N+1 distinct codes.
   function automatic int cnt_width(input int n);
      return $clog2(2 * n + 1);
   endfunction

endpackage

// File: rtl/div_seq_restoring_if.sv
// Request/result bundle between a divider client and div_seq_restoring.
interface div_seq_restoring_if
   import div_pkg::*;
#(
   parameter int N = N_DEFAULT
);
   logic             start;
   logic [2*N-1:0]   dividend;
   logic [N-1:0]     divisor;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [2*N-1:0]   quotient;
   logic [N-1:0]     remainder;

   modport master (
      output start, dividend, divisor,
      input  busy, done, div_by_zero, quotient, remainder
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, div_by_zero, quotient, remainder
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step #(
   parameter int N = 4
) (
   input  logic [N-1:0] pr_in,
   input  logic         bit_in,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] pr_out,
   output logic         q_bit
);
   logic [N:0] shifted;

   // pr_in < divisor always holds, so the N+1-bit trial value minus the
   // divisor (or the value itself when it does not fit) always fits N bits.
   assign shifted = {pr_in, bit_in};
   assign q_bit   = (shifted >= {1'b0, divisor});
   assign pr_out  = q_bit ? N'(shifted - {1'b0, divisor}) : shifted[N-1:0];
endmodule

// File: rtl/div_seq_restoring.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | iterating, one quotient bit per edge
//   DONE  | single cycle, results valid and done pulsed
module div_seq_restoring
   import div_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   div_seq_restoring_if.slave bus
);
   localparam int            CW       = cnt_width(N);
   localparam logic [CW-1:0] CNT_INIT = CW'(2 * N);

   state_t          state, state_nxt;
   logic [2*N-1:0]  dq;
   logic [N-1:0]    pr;
   logic [N-1:0]    dvs;
   logic [CW-1:0]   cnt;
   logic [2*N-1:0]  quo;
   logic [N-1:0]    rem;
   logic            dbz;

   logic            accept;
   logic            zero_dvs;
   logic            last;
   logic [N-1:0]    pr_nxt;
   logic            q_bit;
   logic [2*N-1:0]  dq_nxt;

   assign accept   = bus.start && (state == IDLE || state == DONE);
   assign zero_dvs = (bus.divisor == '0);
   assign last     = (cnt == CW'(1));
   assign dq_nxt   = {dq[2*N-2:0], q_bit};

   div_step #(.N(N)) u_step (
      .pr_in   (pr),
      .bit_in  (dq[2*N-1]),
      .divisor (dvs),
      .pr_out  (pr_nxt),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = zero_dvs ? DONE : RUN;
         RUN:     if (last)   state_nxt = DONE;
         DONE:    state_nxt = accept ? (zero_dvs ? DONE : RUN) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq  <= '0;
         pr  <= '0;
         dvs <= '0;
         cnt <= '0;
         quo <= '0;
         rem <= '0;
         dbz <= 1'b0;
      end else if (accept) begin
         dq  <= bus.dividend;
         dvs <= bus.divisor;
         pr  <= '0;
         cnt <= CNT_INIT;
         dbz <= 1'b0;
         if (zero_dvs) begin
            quo <= '1;
            rem <= bus.dividend[N-1:0];
            dbz <= 1'b1;
         end
      end else if (state == RUN) begin
         dq  <= dq_nxt;
         pr  <= pr_nxt;
         cnt <= cnt - CW'(1);
         if (last) begin
            quo <= dq_nxt;
            rem <= pr_nxt;
         end
      end
   end

   assign bus.busy        = (state == RUN);
   assign bus.done        = (state == DONE);
   assign bus.div_by_zero = dbz;
   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
endmodule

// File: doc/div_seq_restoring.md
Name: div_seq_restoring

Overview:
- Sequential restoring integer divider, the inverse operation of the team's carry-save array multiplier.
- Takes a 2N-bit dividend and an N-bit divisor. Produces a 2N-bit quotient and an N-bit remainder after 2N iterations, one quotient bit per clock.
- Used wherever a multiplier product must be reduced back to its factors, and as the self-checking partner of the multiplier in integration benches (quotient of product/multiplier = multiplicand).

Parameters:
- N, 4, divisor/remainder width; dividend and quotient are 2N bits. Legal N >= 2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising edge while ready.
- dividend  input  2N  captured on accepted start.
- divisor  input  N  captured on accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  set with done when captured divisor == 0; held with results.
- quotient  output  2N  result; holds until next accepted start.
- remainder  output  N  result; holds until next accepted start.

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; internal counter/registers cleared. Reset mid-operation aborts the division immediately with no done pulse.
- States:
  - IDLE: wait for start.
  - RUN: iterating.
  - DONE: one cycle, done=1.
- Accepting start:
  - start is accepted in IDLE and in DONE, which allows back-to-back operation. It is ignored in RUN.
  - On accept, dividend and divisor are captured into internal registers, the partial remainder (N+1 bits) is cleared, the iteration counter is loaded with 2N, and div_by_zero is cleared.
  - On accept with divisor != 0: next state RUN.
  - On accept with divisor == 0: next state DONE directly. quotient = all ones (2^(2N)-1), remainder = dividend[N-1:0], div_by_zero=1. done is seen the cycle after the accepting edge.
- RUN iteration (each edge):
  - pr = {pr[N-1:0], dq[2N-1]}; dq shifts left.
  - If pr >= divisor: pr = pr - divisor and dq[0]=1; else dq[0]=0.
  - The counter decrements. On the edge where the counter reaches 0, quotient = dq and remainder = pr[N-1:0]; the next state is DONE.
- Latency: start accepted at edge t0 -> RUN for edges t0+1 .. t0+2N -> done=1 during the cycle following edge t0+2N. This is 2N+1 cycles from accept to done.
- busy=1 exactly while in RUN. done=1 exactly while in DONE.
- Arithmetic invariant: pr < divisor before every shift, so N+1 bits suffice. Results satisfy dividend = quotient*divisor + remainder and remainder < divisor.
- Inputs dividend and divisor may change freely after acceptance without affecting the operation.
- start held high continuously: a new operation starts from every DONE cycle.
- Outputs quotient, remainder and div_by_zero are registered, with no combinational path from inputs.

Decomposition:
- Shared package div_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam for the counter width, $clog2(2N+1)
- Sub-module div_step (combinational): one restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Reusable by a future unrolled/pipelined divider.

Test Plan (N=4):
1. dividend=200, divisor=7, start one cycle -> busy 8 cycles, done on cycle 9 after accept; quotient=28, remainder=4, div_by_zero=0.
2. dividend=255, divisor=0 -> done the cycle after accept, busy never high; quotient=255, remainder=15, div_by_zero=1.
3. Back-to-back: start held high with 240/15 then 0/5 -> quotient=16 r0, then quotient=0 r0. The second operation is accepted in the DONE cycle of the first, with no IDLE gap. start pulses during RUN are ignored, and the first result is unchanged.
4. Reset mid-operation: start 255/1, deassert rst_n at the 4th RUN cycle -> all outputs 0 asynchronously and no done pulse. A fresh 255/1 then gives quotient=255 r0.
5. Exhaustive: all 256 dividends x 16 divisors in sequence -> quotient/remainder match dividend/divisor and dividend%divisor for divisor != 0, and the div-by-zero rule for 0. Error count reported and must be 0.
6. Loopback with the multiplier: for all A,B in 1..15, divide A*B by B -> quotient=A, remainder=0.
